// File: rtl/priv_1_11_clint.sv
// priv_1_11_clint: machine timer (mtime/mtimecmp) and software interrupt (msip)
// source for the M-mode-only priv_1_11 block, mapped on a single-cycle word bus.
// Optional build macro: CLINT_PRESCALE_EN -- when defined, mtime advances once
// every PRESCALE cycles; when undefined, mtime advances on every cycle.
module priv_1_11_clint #(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int unsigned PRESCALE  = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] addr,
   input  logic        wen,
   input  logic        ren,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        bus_err,
   output logic        timer_int,
   output logic        soft_int
);

   localparam int unsigned CNT_W  = 64;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned PRE_W  = 16;

   localparam logic [WORD_W-1:0] OFF_MSIP    = 32'h0000_0000;
   localparam logic [WORD_W-1:0] OFF_CMP_LO  = 32'h0000_4000;
   localparam logic [WORD_W-1:0] OFF_CMP_HI  = 32'h0000_4004;
   localparam logic [WORD_W-1:0] OFF_TIME_LO = 32'h0000_BFF8;
   localparam logic [WORD_W-1:0] OFF_TIME_HI = 32'h0000_BFFC;

   // Elaboration-time guard on the tick period
   if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
      $error("priv_1_11_clint: PRESCALE must be in 1..65535");
   end

   // Architectural state
   logic [CNT_W-1:0]  mtime;
   logic [CNT_W-1:0]  mtimecmp;
   logic              msip;

   // Next-state values
   logic [CNT_W-1:0]  mtime_next;
   logic [CNT_W-1:0]  mtimecmp_next;
   logic              msip_next;
   logic [WORD_W-1:0] rdata_next;
   logic              ack_next;
   logic              bus_err_next;

   // Bus decode
   logic [WORD_W-1:0] offset;
   logic              aligned;
   logic              sel_msip;
   logic              sel_cmp_lo;
   logic              sel_cmp_hi;
   logic              sel_time_lo;
   logic              sel_time_hi;
   logic              mapped;
   logic              req;
   logic              conflict;
   logic              do_write;
   logic              do_read;
   logic              wr_time_lo;
   logic              wr_time_hi;
   logic              wr_time;
   logic              tick;

   assign offset      = addr - BASE_ADDR;
   assign aligned     = (addr[1:0] == 2'b00);
   assign sel_msip    = aligned && (offset == OFF_MSIP);
   assign sel_cmp_lo  = aligned && (offset == OFF_CMP_LO);
   assign sel_cmp_hi  = aligned && (offset == OFF_CMP_HI);
   assign sel_time_lo = aligned && (offset == OFF_TIME_LO);
   assign sel_time_hi = aligned && (offset == OFF_TIME_HI);
   assign mapped      = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;

   // A simultaneous read and write is rejected outright: neither side happens
   assign req         = wen | ren;
   assign conflict    = wen & ren;
   assign do_write    = wen & ~ren & mapped;
   assign do_read     = ren & ~wen & mapped;
   assign wr_time_lo  = do_write & sel_time_lo;
   assign wr_time_hi  = do_write & sel_time_hi;
   assign wr_time     = wr_time_lo | wr_time_hi;

`ifdef CLINT_PRESCALE_EN
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] pre_cnt;
   logic [PRE_W-1:0] pre_cnt_next;

   // Tick when the phase counter reaches its last value
   assign tick = (pre_cnt == PRE_LAST);

   // Prescale phase: wraps at PRESCALE-1, restarts on any mtime write
   always_comb begin : pre_next_logic
      pre_cnt_next = pre_cnt + PRE_W'(1);
      if (wr_time || tick) begin
         pre_cnt_next = '0;
      end
   end

   // Prescale phase register
   always_ff @(posedge CLK) begin : pre_reg
      if (RST) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt_next;
      end
   end
`else
   // Without a prescaler every cycle advances mtime
   assign tick = 1'b1;
`endif

   // Counter and register next state; a bus write to mtime suppresses that edge's increment
   always_comb begin : state_next_logic
      mtime_next    = mtime;
      mtimecmp_next = mtimecmp;
      msip_next     = msip;

      if (wr_time_lo) begin
         mtime_next[WORD_W-1:0] = wdata;
      end else if (wr_time_hi) begin
         mtime_next[CNT_W-1:WORD_W] = wdata;
      end else if (tick) begin
         mtime_next = mtime + CNT_W'(1);
      end

      if (do_write && sel_cmp_lo) begin
         mtimecmp_next[WORD_W-1:0] = wdata;
      end
      if (do_write && sel_cmp_hi) begin
         mtimecmp_next[CNT_W-1:WORD_W] = wdata;
      end

      if (do_write && sel_msip) begin
         msip_next = wdata[0];
      end
   end

   // Read mux and handshake response, captured from pre-edge state
   always_comb begin : bus_next_logic
      rdata_next   = '0;
      ack_next     = req;
      bus_err_next = req & (conflict | ~mapped);

      if (do_read) begin
         unique case (1'b1)
            sel_msip:    rdata_next = {31'd0, msip};
            sel_cmp_lo:  rdata_next = mtimecmp[WORD_W-1:0];
            sel_cmp_hi:  rdata_next = mtimecmp[CNT_W-1:WORD_W];
            sel_time_lo: rdata_next = mtime[WORD_W-1:0];
            sel_time_hi: rdata_next = mtime[CNT_W-1:WORD_W];
            default:     rdata_next = '0;
         endcase
      end
   end

   // State, bus response and interrupt registers; interrupts track post-edge values
   always_ff @(posedge CLK) begin : main_reg
      if (RST) begin
         mtime     <= '0;
         mtimecmp  <= '1;
         msip      <= 1'b0;
         rdata     <= '0;
         ack       <= 1'b0;
         bus_err   <= 1'b0;
         timer_int <= 1'b0;
         soft_int  <= 1'b0;
      end else begin
         mtime     <= mtime_next;
         mtimecmp  <= mtimecmp_next;
         msip      <= msip_next;
         rdata     <= rdata_next;
         ack       <= ack_next;
         bus_err   <= bus_err_next;
         timer_int <= (mtime_next >= mtimecmp_next);
         soft_int  <= msip_next;
      end
   end

endmodule

// File: tb/tb_priv_1_11_clint.sv
// tb_priv_1_11_clint: directed checks of the CLINT in its default build
// (mtime advances every cycle). Inputs change on falling edges; outputs are
// observed on the falling edge following each request.
module tb_priv_1_11_clint;

   localparam logic [31:0] BASE = 32'h0200_0000;
   localparam logic [31:0] A_MSIP   = BASE + 32'h0000;
   localparam logic [31:0] A_CMP_LO = BASE + 32'h4000;
   localparam logic [31:0] A_CMP_HI = BASE + 32'h4004;
   localparam logic [31:0] A_T_LO   = BASE + 32'hBFF8;
   localparam logic [31:0] A_T_HI   = BASE + 32'hBFFC;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic        wen;
   logic        ren;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        bus_err;
   logic        timer_int;
   logic        soft_int;

   int total_checks;
   int failed_checks;

   logic [31:0] rd;
   logic        ak;
   logic        er;

   priv_1_11_clint dut (
      .CLK       (clk),
      .RST       (rst),
      .addr      (addr),
      .wen       (wen),
      .ren       (ren),
      .wdata     (wdata),
      .rdata     (rdata),
      .ack       (ack),
      .bus_err   (bus_err),
      .timer_int (timer_int),
      .soft_int  (soft_int)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_checks++;
      assert (obs === exp)
      else begin
         failed_checks++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One request cycle: drive at a falling edge, capture the response one cycle later
   task automatic do_req(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
      wen   = w;
      ren   = r;
      addr  = a;
      wdata = d;
      @(negedge clk);
      rd = rdata;
      ak = ack;
      er = bus_err;
      wen   = 1'b0;
      ren   = 1'b0;
      addr  = '0;
      wdata = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      total_checks  = 0;
      failed_checks = 0;
      rst   = 1'b1;
      wen   = 1'b0;
      ren   = 1'b0;
      addr  = '0;
      wdata = '0;

      // Reset for two rising edges
      idle(2);
      rst = 1'b0;
      check("rst_timer_int", 64'(timer_int), 64'd0);
      check("rst_soft_int",  64'(soft_int),  64'd0);
      check("rst_ack",       64'(ack),       64'd0);
      check("rst_bus_err",   64'(bus_err),   64'd0);
      check("rst_rdata",     64'(rdata),     64'd0);

      // mtime counts from 0: one cycle after release it holds 1
      idle(1);
      do_req(1'b0, 1'b1, A_T_LO, '0);
      check("rst_mtime_lo", 64'(rd), 64'd1);
      check("rd_ack",       64'(ak), 64'd1);
      check("rd_err",       64'(er), 64'd0);
      do_req(1'b0, 1'b1, A_CMP_LO, '0);
      check("rst_cmp_lo", 64'(rd), 64'hFFFF_FFFF);
      do_req(1'b0, 1'b1, A_CMP_HI, '0);
      check("rst_cmp_hi", 64'(rd), 64'hFFFF_FFFF);
      idle(1);
      check("idle_ack", 64'(ack), 64'd0);

      // Timer fire at mtimecmp = 20
      do_req(1'b1, 1'b0, A_CMP_HI, 32'd0);
      check("wr_ack", 64'(ak), 64'd1);
      check("wr_err", 64'(er), 64'd0);
      check("cmp_hi0_timer", 64'(timer_int), 64'd0);
      do_req(1'b1, 1'b0, A_CMP_LO, 32'd20);
      check("cmp_lo20_timer", 64'(timer_int), 64'd0);
      do_req(1'b1, 1'b0, A_T_LO, 32'd10);
      check("mtime10_timer", 64'(timer_int), 64'd0);
      idle(9);
      check("mtime19_timer", 64'(timer_int), 64'd0);
      idle(1);
      check("mtime20_timer", 64'(timer_int), 64'd1);
      idle(3);
      check("mtime23_timer", 64'(timer_int), 64'd1);
      do_req(1'b1, 1'b0, A_CMP_LO, 32'hFFFF_FFFF);
      check("cmp_raise_timer", 64'(timer_int), 64'd0);

      // Write beats increment on the same edge
      do_req(1'b1, 1'b0, A_T_LO, 32'd5);
      do_req(1'b0, 1'b1, A_T_LO, '0);
      check("collide_lo", 64'(rd), 64'd5);
      do_req(1'b0, 1'b1, A_T_HI, '0);
      check("collide_hi", 64'(rd), 64'd0);

      // mtimecmp = 0x1_0000_0000, then wrap mtime through 2^64
      do_req(1'b1, 1'b0, A_CMP_HI, 32'hFFFF_FFFF);
      do_req(1'b1, 1'b0, A_CMP_LO, 32'd0);
      do_req(1'b1, 1'b0, A_CMP_HI, 32'd1);
      check("cmp_1_0_timer", 64'(timer_int), 64'd0);
      do_req(1'b1, 1'b0, A_T_LO, 32'hFFFF_FFFE);
      check("t_lo_fffe_timer", 64'(timer_int), 64'd0);
      do_req(1'b1, 1'b0, A_T_HI, 32'hFFFF_FFFF);
      check("t_max_m1_timer", 64'(timer_int), 64'd1);
      idle(1);
      check("t_max_timer", 64'(timer_int), 64'd1);
      idle(1);
      check("wrap_timer", 64'(timer_int), 64'd0);
      do_req(1'b0, 1'b1, A_T_LO, '0);
      check("wrap_lo", 64'(rd), 64'd0);
      do_req(1'b0, 1'b1, A_T_HI, '0);
      check("wrap_hi", 64'(rd), 64'd0);

      // Carry from lo into hi
      do_req(1'b1, 1'b0, A_T_LO, 32'hFFFF_FFFF);
      check("pre_carry_timer", 64'(timer_int), 64'd0);
      do_req(1'b0, 1'b1, A_T_HI, '0);
      check("pre_carry_hi", 64'(rd), 64'd0);
      check("carry_timer", 64'(timer_int), 64'd1);
      do_req(1'b0, 1'b1, A_T_HI, '0);
      check("carry_hi", 64'(rd), 64'd1);
      do_req(1'b0, 1'b1, A_T_LO, '0);
      check("carry_lo", 64'(rd), 64'd1);

      // Bus errors
      do_req(1'b0, 1'b1, BASE + 32'h0100, '0);
      check("unmapped_ack",   64'(ak), 64'd1);
      check("unmapped_err",   64'(er), 64'd1);
      check("unmapped_rdata", 64'(rd), 64'd0);
      do_req(1'b1, 1'b0, BASE + 32'h4002, 32'h0000_1234);
      check("misalign_ack", 64'(ak), 64'd1);
      check("misalign_err", 64'(er), 64'd1);
      do_req(1'b0, 1'b1, A_CMP_LO, '0);
      check("misalign_cmp_lo", 64'(rd), 64'd0);
      check("misalign_rd_err", 64'(er), 64'd0);
      do_req(1'b1, 1'b1, A_MSIP, 32'd1);
      check("both_ack",   64'(ak), 64'd1);
      check("both_err",   64'(er), 64'd1);
      check("both_rdata", 64'(rd), 64'd0);
      check("both_soft",  64'(soft_int), 64'd0);
      do_req(1'b0, 1'b1, A_MSIP, '0);
      check("both_msip", 64'(rd), 64'd0);

      // Software interrupt
      do_req(1'b1, 1'b0, A_MSIP, 32'hFFFF_FFFF);
      check("msip_set_soft", 64'(soft_int), 64'd1);
      do_req(1'b0, 1'b1, A_MSIP, '0);
      check("msip_read", 64'(rd), 64'd1);
      do_req(1'b1, 1'b0, A_MSIP, 32'd0);
      check("msip_clr_soft", 64'(soft_int), 64'd0);

      // Reset drops an in-flight request
      do_req(1'b1, 1'b0, A_MSIP, 32'd1);
      rst  = 1'b1;
      ren  = 1'b1;
      addr = A_CMP_LO;
      @(negedge clk);
      rst  = 1'b0;
      ren  = 1'b0;
      addr = '0;
      check("rst_flight_ack",  64'(ack),      64'd0);
      check("rst_flight_soft", 64'(soft_int), 64'd0);
      idle(1);
      check("rst_flight_ack2", 64'(ack), 64'd0);
      do_req(1'b0, 1'b1, A_T_LO, '0);
      check("rst2_mtime_lo", 64'(rd), 64'd1);
      do_req(1'b0, 1'b1, A_CMP_HI, '0);
      check("rst2_cmp_hi", 64'(rd), 64'hFFFF_FFFF);

      $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
      $finish;
   end

endmodule
